// File: rtl/ttlut_pkg.sv
// Shared types and sizing helpers for the truth-table LUT evaluator.
package ttlut_pkg;

    // Controller states: no table yet, table load in progress, table usable.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } ttlut_state_e;

    // Number of cfg beats needed to fill a 2**n_in entry table.
    function automatic int chunk_count(input int n_in, input int cfg_w);
        return (1 << n_in) / cfg_w;
    endfunction

    // Width of the chunk counter; at least one bit even for single-beat loads.
    function automatic int cnt_width(input int n_in, input int cfg_w);
        int c;
        c = chunk_count(n_in, cfg_w);
        return (c <= 1) ? 1 : $clog2(c);
    endfunction

endpackage

// File: rtl/ttlut_loader.sv
// Table loader: chunk counter, shadow table and commit strobe.
// The commit table already contains the final chunk so the active table
// can be written in the same cycle the last beat is accepted.
module ttlut_loader
    import ttlut_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int CFG_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   beat,
    input  logic [CFG_W-1:0]       cfg_data,
    output logic                   commit,
    output logic [(1<<N_IN)-1:0]   commit_tbl
);

    localparam int N_CHUNK = chunk_count(N_IN, CFG_W);
    localparam int CNT_W   = cnt_width(N_IN, CFG_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_CHUNK - 1);

    logic [CNT_W-1:0]       cnt;
    logic [(1<<N_IN)-1:0]   shadow;
    logic                   take;

    // A restart pulse wins over a coincident beat; the beat is dropped.
    assign take   = beat && !clear;
    assign commit = take && (cnt == LAST);

    // Shadow table with the current beat merged in at its chunk position.
    always_comb begin
        commit_tbl = shadow;
        commit_tbl[cnt*CFG_W +: CFG_W] = cfg_data;
    end

    // Counter and shadow storage; counter wraps to 0 after the final chunk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            shadow <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (take) begin
            shadow <= commit_tbl;
            cnt    <= commit ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ttlut_eval.sv
// Truth-table LUT evaluator: loads a 2**N_IN entry table in CFG_W-bit
// beats and answers single-bit lookups with a one-cycle registered result.
// Optional build macro TTLUT_ONES_CNT_EN adds a saturating ones_cnt output
// counting consumed results whose bit was 1.
module ttlut_eval
    import ttlut_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int CFG_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CFG_W-1:0]  cfg_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic              tbl_loaded
`ifdef TTLUT_ONES_CNT_EN
    ,
    output logic [15:0]       ones_cnt
`endif
);

    localparam int TBL_W = 1 << N_IN;

    if (N_IN < 1 || N_IN > 8) begin : g_bad_n_in
        $fatal(1, "ttlut_eval: N_IN must be in 1..8");
    end
    if (CFG_W < 1 || (TBL_W % CFG_W) != 0) begin : g_bad_cfg_w
        $fatal(1, "ttlut_eval: CFG_W must divide 2**N_IN");
    end

    ttlut_state_e       state;
    logic [TBL_W-1:0]   active_tbl;
    logic [TBL_W-1:0]   commit_tbl;
    logic               commit;
    logic               beat;
    logic               accept;

    // Handshake: beats only in LOAD; requests whenever not loading and
    // the result register is empty or being drained this cycle.
    assign cfg_ready = (state == LOAD);
    assign beat      = cfg_valid && cfg_ready;
    assign in_ready  = (state != LOAD) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;

    ttlut_loader #(
        .N_IN  (N_IN),
        .CFG_W (CFG_W)
    ) u_loader (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (cfg_start),
        .beat       (beat),
        .cfg_data   (cfg_data),
        .commit     (commit),
        .commit_tbl (commit_tbl)
    );

    // Control FSM; the active table only changes on a complete load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tbl_loaded <= 1'b0;
            active_tbl <= '0;
        end else if (cfg_start) begin
            state      <= LOAD;
            tbl_loaded <= 1'b0;
        end else if (commit) begin
            state      <= ACTIVE;
            tbl_loaded <= 1'b1;
            active_tbl <= commit_tbl;
        end
    end

    // Result register: loads on accept, holds while stalled, empties on consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_bit   <= (state == ACTIVE) ? active_tbl[in_data] : 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef TTLUT_ONES_CNT_EN
    // Saturating count of consumed results equal to 1; restart clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_cnt <= '0;
        end else if (cfg_start) begin
            ones_cnt <= '0;
        end else if (out_valid && out_ready && out_bit && (ones_cnt != 16'hFFFF)) begin
            ones_cnt <= ones_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ttlut_eval.sv
// Bench for ttlut_eval: a default-parameter instance (dut_a) and an
// N_IN=4/CFG_W=4 instance (dut_b) sharing clock and reset.
module tb_ttlut_eval;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       a_cfg_start, a_cfg_valid, a_cfg_ready;
    logic [7:0] a_cfg_data;
    logic       a_in_valid, a_in_ready;
    logic [2:0] a_in_data;
    logic       a_out_valid, a_out_ready, a_out_bit, a_tbl_loaded;

    logic       b_cfg_start, b_cfg_valid, b_cfg_ready;
    logic [3:0] b_cfg_data;
    logic       b_in_valid, b_in_ready;
    logic [3:0] b_in_data;
    logic       b_out_valid, b_out_ready, b_out_bit, b_tbl_loaded;

`ifdef TTLUT_ONES_CNT_EN
    logic [15:0] a_ones_cnt, b_ones_cnt;
`endif

    ttlut_eval dut_a (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(a_cfg_start), .cfg_valid(a_cfg_valid), .cfg_ready(a_cfg_ready),
        .cfg_data(a_cfg_data),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_bit(a_out_bit),
        .tbl_loaded(a_tbl_loaded)
`ifdef TTLUT_ONES_CNT_EN
        , .ones_cnt(a_ones_cnt)
`endif
    );

    ttlut_eval #(.N_IN(4), .CFG_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(b_cfg_start), .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready),
        .cfg_data(b_cfg_data),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_bit(b_out_bit),
        .tbl_loaded(b_tbl_loaded)
`ifdef TTLUT_ONES_CNT_EN
        , .ones_cnt(b_ones_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the table as last fully loaded, and whether one exists.
    logic [7:0]  a_m_tbl = '0;
    logic        a_m_active = 1'b0;
    logic [15:0] b_m_tbl = '0;
    logic        b_m_active = 1'b0;
    // Results accepted by dut_a but not yet consumed.
    logic        a_exp_q[$];

    function automatic logic a_model(input logic [2:0] idx);
        return a_m_active ? a_m_tbl[idx] : 1'b0;
    endfunction

    function automatic logic b_model(input logic [3:0] idx);
        return b_m_active ? b_m_tbl[idx] : 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- dut_a drivers ----------------
    task automatic a_load(input logic [7:0] t);
        a_cfg_start = 1'b1;
        tick();
        a_cfg_start = 1'b0;
        check("a_cfg_ready_in_load", a_cfg_ready, 1);
        check("a_loaded_in_load", a_tbl_loaded, 0);
        a_cfg_valid = 1'b1;
        a_cfg_data  = t;
        tick();
        a_cfg_valid = 1'b0;
        check("a_cfg_ready_after_load", a_cfg_ready, 0);
        check("a_tbl_loaded", a_tbl_loaded, 1);
        a_m_tbl    = t;
        a_m_active = 1'b1;
    endtask

    task automatic a_eval(input logic [2:0] idx);
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data   = idx;
        #1;
        check("a_eval_in_ready", a_in_ready, 1);
        tick();
        a_in_valid = 1'b0;
        check("a_eval_out_valid", a_out_valid, 1);
        check("a_eval_out_bit", a_out_bit, a_model(idx));
    endtask

    task automatic a_drain();
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        tick();
        check("a_drain_out_valid", a_out_valid, 0);
    endtask

    // Random valid/ready traffic against a one-deep pending-result model.
    task automatic a_random(input int n);
        for (int i = 0; i < n; i++) begin
            logic exp_rdy;
            a_in_valid  = 1'($urandom_range(0, 1));
            a_in_data   = 3'($urandom_range(0, 7));
            a_out_ready = 1'($urandom_range(0, 1));
            #1;
            exp_rdy = (a_exp_q.size() == 0) || a_out_ready;
            check("a_rnd_in_ready", a_in_ready, exp_rdy);
            check("a_rnd_out_valid", a_out_valid, a_exp_q.size() != 0);
            if (a_exp_q.size() != 0) begin
                check("a_rnd_out_bit", a_out_bit, a_exp_q[0]);
                if (a_out_ready) void'(a_exp_q.pop_front());
            end
            if (a_in_valid && exp_rdy) a_exp_q.push_back(a_model(a_in_data));
            tick();
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        #1;
        if (a_exp_q.size() != 0) begin
            check("a_rnd_last_bit", a_out_bit, a_exp_q[0]);
            void'(a_exp_q.pop_front());
        end
        tick();
        check("a_rnd_drained", a_out_valid, 0);
    endtask

    // ---------------- dut_b drivers ----------------
    task automatic b_beat(input logic [3:0] d);
        b_cfg_valid = 1'b1;
        b_cfg_data  = d;
        #1;
        check("b_beat_cfg_ready", b_cfg_ready, 1);
        tick();
        b_cfg_valid = 1'b0;
    endtask

    task automatic b_load(input logic [15:0] t);
        b_cfg_start = 1'b1;
        tick();
        b_cfg_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("b_loaded_mid_load", b_tbl_loaded, 0);
            b_beat(t[k*4 +: 4]);
        end
        check("b_tbl_loaded", b_tbl_loaded, 1);
        check("b_cfg_ready_after", b_cfg_ready, 0);
        b_m_tbl    = t;
        b_m_active = 1'b1;
    endtask

    task automatic b_eval(input logic [3:0] idx, input logic exp);
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_data   = idx;
        #1;
        check("b_eval_in_ready", b_in_ready, 1);
        tick();
        b_in_valid = 1'b0;
        check("b_eval_out_valid", b_out_valid, 1);
        check("b_eval_out_bit", b_out_bit, exp);
    endtask

    task automatic b_drain();
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        tick();
        check("b_drain_out_valid", b_out_valid, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        a_cfg_start = 0; a_cfg_valid = 0; a_cfg_data = '0;
        a_in_valid = 0; a_in_data = '0; a_out_ready = 1'b1;
        b_cfg_start = 0; b_cfg_valid = 0; b_cfg_data = '0;
        b_in_valid = 0; b_in_data = '0; b_out_ready = 1'b1;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_out_bit", a_out_bit, 0);
        check("rst_a_cfg_ready", a_cfg_ready, 0);
        check("rst_a_tbl_loaded", a_tbl_loaded, 0);
        check("rst_b_out_valid", b_out_valid, 0);
        check("rst_b_tbl_loaded", b_tbl_loaded, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("rst_a_in_ready", a_in_ready, 1);
        check("rst_b_in_ready", b_in_ready, 1);
        check("rst_b_cfg_ready", b_cfg_ready, 0);

        // Evaluation with no table returns 0
        a_eval(3'd5);
        check("idle_a_bit5", a_out_bit, 0);
        check("idle_a_tbl_loaded", a_tbl_loaded, 0);
        a_drain();

        // Table 0x0E, back-to-back lookups over every minterm
        a_load(8'h0E);
        for (int i = 0; i < 8; i++) a_eval(3'(i));
        a_drain();

        // Output stall: result held, no new request accepted
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 3'd1;
        tick();
        a_in_data = 3'd4;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_out_valid", a_out_valid, 1);
            check("stall_out_bit", a_out_bit, 1);
            check("stall_in_ready", a_in_ready, 0);
            tick();
        end
        a_out_ready = 1'b1;
        #1;
        check("stall_release_in_ready", a_in_ready, 1);
        tick();
        a_in_valid = 1'b0;
        check("stall_next_valid", a_out_valid, 1);
        check("stall_next_bit", a_out_bit, 0);
        a_drain();

        // Random tables with random valid/ready traffic
        for (int r = 0; r < 4; r++) begin
            a_load(8'($urandom));
            a_random(150);
        end

        // Four-beat table 0xF00A
        b_load(16'hF00A);
        b_eval(4'd1, 1'b1);
        b_eval(4'd15, 1'b1);
        for (int i = 0; i < 16; i++) b_eval(4'(i), b_model(4'(i)));
        b_drain();

        // Request in the same cycle as cfg_start uses the old table
        b_in_valid  = 1'b1;
        b_in_data   = 4'd3;
        b_cfg_start = 1'b1;
        #1;
        check("same_cycle_in_ready", b_in_ready, 1);
        tick();
        b_cfg_start = 1'b0;
        b_in_valid  = 1'b0;
        check("same_cycle_out_valid", b_out_valid, 1);
        check("same_cycle_old_bit", b_out_bit, 1);
        check("same_cycle_tbl_loaded", b_tbl_loaded, 0);
        check("load_in_ready", b_in_ready, 0);

        // Partial load then restart with a coincident (discarded) beat
        b_beat(4'h5);
        b_beat(4'h5);
        b_cfg_start = 1'b1;
        b_cfg_valid = 1'b1;
        b_cfg_data  = 4'h7;
        tick();
        b_cfg_start = 1'b0;
        b_cfg_valid = 1'b0;
        check("partial_active_tbl", dut_b.active_tbl, 16'hF00A);
        check("partial_tbl_loaded", b_tbl_loaded, 0);
        b_beat(4'h3);
        b_beat(4'hC);
        b_beat(4'h0);
        check("restart_not_early", b_tbl_loaded, 0);
        b_beat(4'h1);
        check("restart_loaded", b_tbl_loaded, 1);
        b_m_tbl = 16'h10C3;
        for (int i = 0; i < 16; i++) b_eval(4'(i), b_model(4'(i)));
        b_drain();

        // Reset mid-load with a stalled result pending
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_data   = 4'd0;
        tick();
        b_in_valid = 1'b0;
        check("pend_out_valid", b_out_valid, 1);
        b_cfg_start = 1'b1;
        tick();
        b_cfg_start = 1'b0;
        b_beat(4'h9);
        check("pend_held", b_out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", b_out_valid, 0);
        check("midrst_out_bit", b_out_bit, 0);
        check("midrst_tbl_loaded", b_tbl_loaded, 0);
        check("midrst_cfg_ready", b_cfg_ready, 0);
        check("midrst_active_tbl", dut_b.active_tbl, 0);
        #1 rst_n = 1'b1;
        b_m_active = 1'b0;
        a_m_active = 1'b0;
        tick();
        check("postrst_in_ready", b_in_ready, 1);
        check("postrst_out_valid", b_out_valid, 0);
        b_eval(4'd15, 1'b0);
        b_eval(4'd0, 1'b0);
        b_drain();

`ifdef TTLUT_ONES_CNT_EN
        check("ones_after_rst", a_ones_cnt, 0);
        a_load(8'hFF);
        for (int i = 0; i < 5; i++) a_eval(3'($urandom_range(0, 7)));
        a_drain();
        check("ones_five", a_ones_cnt, 5);
        a_in_valid  = 1'b1;
        a_out_ready = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            a_in_data = 3'($urandom_range(0, 7));
            tick();
        end
        check("ones_saturated", a_ones_cnt, 16'hFFFF);
        a_in_valid  = 1'b0;
        a_cfg_start = 1'b1;
        tick();
        a_cfg_start = 1'b0;
        check("ones_cleared", a_ones_cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
